// File: rtl/adder_seq_ctrl.sv
// Multi-word add/subtract sequencer driving one shared external 4-bit adder slice.
// Operands are processed one nibble per cycle, LSB first, with the carry chained through c_r.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           c_r;
    logic [3:0]     idx_r;
    logic [W-1:0]   result_r;
    logic           carry_out_r;
    logic           overflow_r;
    logic           busy_r;
    logic           done_r;
    logic           last_s;
    logic [W-1:0]   a_sh_s;
    logic [W-1:0]   b_sh_s;

    assign last_s    = (idx_r == 4'(NIBBLES - 1));
    assign a_sh_s    = a_r >> {idx_r, 2'b00};
    assign b_sh_s    = b_r >> {idx_r, 2'b00};
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Slice drive: zero outside RUN so the shared adder sees quiet inputs
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_r == ST_RUN) begin
            add_a   = a_sh_s[3:0];
            add_b   = b_sh_s[3:0];
            add_cin = c_r;
        end else begin
            add_a   = 4'd0;
            add_b   = 4'd0;
            add_cin = 1'b0;
        end
    end

    // Datapath: operand latch, nibble write-back, carry chain and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            c_r         <= 1'b0;
            idx_r       <= 4'd0;
            result_r    <= {W{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r         <= op_a;
                        b_r         <= sub ? ~op_b : op_b;
                        c_r         <= sub ? 1'b1 : cin;
                        idx_r       <= 4'd0;
                        result_r    <= {W{1'b0}};
                        carry_out_r <= 1'b0;
                        overflow_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_r == 4'(i)) begin
                            result_r[4*i +: 4] <= add_sum;
                        end
                    end
                    c_r <= add_cout;
                    if (last_s) begin
                        // idx parks at 0 instead of stepping past the top slice
                        idx_r       <= 4'd0;
                        carry_out_r <= add_cout;
                        overflow_r  <= (a_r[W-1] == b_r[W-1]) && (add_sum[3] != a_r[W-1]);
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    idx_r <= 4'd0;
                end
                default: begin
                    idx_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NIBBLES=4): constant vector table, handshake and
// reset corner sequences, and random operations checked against an integer arithmetic model.
module tb_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_res = 16'h0000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        logic [15:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[5];

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    // Correct external 4-bit slice
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  input logic s, output logic [15:0] r, output logic co,
                                  output logic ov);
        int ua, ub, sa, sb, us, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            us = ua - ub;
            ss = sa - sb;
            co = (ua >= ub);
        end else begin
            us = ua + ub + int'(c);
            ss = sa + sb + int'(c);
            co = (us > 65535);
        end
        r  = 16'(us);
        ov = (ss > 32767) || (ss < -32768);
    endfunction

    // Called at the negedge of the first RUN cycle; returns at the negedge of the DONE cycle
    task automatic check_run(input logic [15:0] a, input logic [15:0] b, input logic c,
                             input logic s, input logic [15:0] er, input logic eco,
                             input logic eov);
        logic [15:0] bb;
        bb = s ? ~b : b;
        for (int k = 0; k < 4; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("add_a", 32'(add_a), 32'((a >> (4 * k)) & 16'h000F));
            chk("add_b", 32'(add_b), 32'((bb >> (4 * k)) & 16'h000F));
            if (k == 0) begin
                chk("add_cin", 32'(add_cin), s ? 32'd1 : 32'(c));
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("result", 32'(result), 32'(er));
        chk("carry_out", 32'(carry_out), 32'(eco));
        chk("overflow", 32'(overflow), 32'(eov));
        last_res = er;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input logic [15:0] er, input logic eco,
                          input logic eov);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_run(a, b, c, s, er, eco, eov);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("result_hold", 32'(result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] er, ra, rb;
        logic        eco, eov, rc, rs;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op_a = 16'h0; op_b = 16'h0; cin = 1'b0; sub = 1'b0;
        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].r, vecs[i].co, vecs[i].ov);
        end

        // start held high, op_a changed during RUN: original operands used, then restart from IDLE
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = 16'h4444;
        check_run(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        chk("hs_idle_done", 32'(done), 32'd0);
        chk("hs_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_run(16'h4444, 16'h2222, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0);
        @(negedge clk);
        chk("hs_one_done", 32'(done), 32'd0);

        // Reset during the second RUN cycle
        op_a = 16'hABCD; op_b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Idle quiet
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_add_a", 32'(add_a), 32'd0);
            chk("idle_add_b", 32'(add_b), 32'd0);
            chk("idle_add_cin", 32'(add_cin), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_result", 32'(result), 32'(last_res));
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            model(ra, rb, rc, rs, er, eco, eov);
            run_op(ra, rb, rc, rs, er, eco, eov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
